// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and constants: buffered entry layout, FSM states, NOP encoding.
package instr_fetch_pkg;

  localparam int unsigned NB_INSTR  = 32;
  localparam int unsigned MEM_SIZE  = 32'h0001_0000;
  localparam logic [NB_INSTR-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]         pc;
    logic [NB_INSTR-1:0] instr;
    logic                fault_misalign;
    logic                fault_range;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFault = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two circular FIFO of fetch entries with synchronous flush.
// The caller guarantees push only when there is room (or a pop) and pop only when non-empty.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads imem combinationally, buffers entries for decode,
// and halts on a misaligned or out-of-range fetch until redirected.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_SIZE   = instr_fetch_pkg::MEM_SIZE,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_fault_misalign,
  output logic        dec_fault_range,
  output logic        fetch_halted
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]  pc_q, pc_d;
  fetch_state_e state_q, state_d;
  logic [CW-1:0] count;
  fetch_entry_t head, new_entry;
  logic push, pop, misalign, out_of_range, fault;

  assign imem_pc      = pc_q;
  assign misalign     = pc_q[1:0] != 2'b00;
  // 33-bit compare so the top of the address space cannot wrap past MEM_SIZE.
  assign out_of_range = ({1'b0, pc_q} + 33'd3) >= 33'(MEM_SIZE);
  assign fault        = misalign | out_of_range;

  assign dec_valid = count != '0;
  assign pop       = dec_valid & dec_ready & ~redirect_valid;
  assign push      = (state_q == StRun) & fetch_en & ~redirect_valid &
                     ((count < CW'(FIFO_DEPTH)) | pop);

  always_comb begin
    new_entry.pc             = pc_q;
    new_entry.instr          = fault ? NOP_INSTR : imem_instruction;
    new_entry.fault_misalign = misalign;
    new_entry.fault_range    = out_of_range;
  end

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = StRun;
    end else if (push) begin
      if (fault) state_d = StFault;
      else       pc_d    = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= StRun;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect_valid),
    .push (push),
    .pop  (pop),
    .wdata(new_entry),
    .rdata(head),
    .count(count)
  );

  always_comb begin
    dec_instr          = '0;
    dec_pc             = '0;
    dec_fault_misalign = 1'b0;
    dec_fault_range    = 1'b0;
    if (dec_valid) begin
      dec_instr          = head.instr;
      dec_pc             = head.pc;
      dec_fault_misalign = head.fault_misalign;
      dec_fault_range    = head.fault_range;
    end
  end

  assign fetch_halted = state_q == StFault;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 256-byte imem whose word at address a is 0xA000_0000 | a.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_fault_misalign;
  logic        dec_fault_range;
  logic        fetch_halted;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_instruction = 32'hA000_0000 | imem_pc;

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .MEM_SIZE  (256),
    .FIFO_DEPTH(2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_en          (fetch_en),
    .imem_pc           (imem_pc),
    .imem_instruction  (imem_instruction),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .dec_valid         (dec_valid),
    .dec_ready         (dec_ready),
    .dec_instr         (dec_instr),
    .dec_pc            (dec_pc),
    .dec_fault_misalign(dec_fault_misalign),
    .dec_fault_range   (dec_fault_range),
    .fetch_halted      (fetch_halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_imem_pc", imem_pc, 32'h0);
    chk("rst_halted", 32'(fetch_halted), 32'd0);
    chk("rst_pc", dec_pc, 32'h0);
    chk("rst_instr", dec_instr, 32'h0);
    #5 rst = 1'b0;

    // Streaming at one per cycle.
    step();
    chk("s0_valid", 32'(dec_valid), 32'd1);
    chk("s0_pc", dec_pc, 32'h0);
    chk("s0_instr", dec_instr, 32'hA000_0000);
    chk("s0_imem_pc", imem_pc, 32'h4);
    step(); chk("s1_pc", dec_pc, 32'h4); chk("s1_instr", dec_instr, 32'hA000_0004);
    step(); chk("s2_pc", dec_pc, 32'h8);
    step(); chk("s3_pc", dec_pc, 32'hC); chk("s3_imem_pc", imem_pc, 32'h10);

    // Fill with two entries (0xC, 0x10), then reset asynchronously between edges.
    dec_ready = 1'b0;
    step(); step();
    chk("full_head", dec_pc, 32'hC);
    chk("full_imem_pc", imem_pc, 32'h14);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(dec_valid), 32'd0);
    chk("arst_imem_pc", imem_pc, 32'h0);
    chk("arst_pc", dec_pc, 32'h0);
    step();
    rst = 1'b0;

    // Backpressure from reset: only 0 and 4 held, PC parked at 8.
    repeat (5) step();
    chk("bp_valid", 32'(dec_valid), 32'd1);
    chk("bp_head", dec_pc, 32'h0);
    chk("bp_imem_pc", imem_pc, 32'h8);
    dec_ready = 1'b1;
    step(); chk("bp_pc1", dec_pc, 32'h4);
    step(); chk("bp_pc2", dec_pc, 32'h8); chk("bp_instr2", dec_instr, 32'hA000_0008);

    // Redirect while full with dec_ready high: head still shown, then flushed.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1 chk("rd_head_shown", dec_pc, 32'h8);
    step();
    redirect_valid = 1'b0;
    chk("rd_flushed", 32'(dec_valid), 32'd0);
    chk("rd_imem_pc", imem_pc, 32'h40);
    step();
    chk("rd_pc", dec_pc, 32'h40);
    chk("rd_instr", dec_instr, 32'hA000_0040);

    // Misaligned redirect target faults on its fetch.
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0; dec_ready = 1'b0;
    step();
    chk("mis_pc", dec_pc, 32'h42);
    chk("mis_instr", dec_instr, 32'h0000_0013);
    chk("mis_flag", 32'(dec_fault_misalign), 32'd1);
    chk("mis_range", 32'(dec_fault_range), 32'd0);
    chk("mis_halted", 32'(fetch_halted), 32'd1);
    chk("mis_imem_pc", imem_pc, 32'h42);
    dec_ready = 1'b1;
    step(); step();
    chk("halt_drained", 32'(dec_valid), 32'd0);
    chk("halt_still", 32'(fetch_halted), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    chk("exit_halted", 32'(fetch_halted), 32'd0);
    step();
    chk("exit_pc", dec_pc, 32'h80);
    chk("exit_flag", 32'(dec_fault_misalign), 32'd0);

    // Range boundary: 0xFC is the last legal word of 256 bytes.
    redirect_valid = 1'b1; redirect_pc = 32'hF8;
    step();
    redirect_valid = 1'b0;
    step(); chk("rg_f8", dec_pc, 32'hF8);
    step();
    chk("rg_fc", dec_pc, 32'hFC);
    chk("rg_fc_range", 32'(dec_fault_range), 32'd0);
    chk("rg_fc_instr", dec_instr, 32'hA000_00FC);
    step();
    chk("rg_100", dec_pc, 32'h100);
    chk("rg_100_range", 32'(dec_fault_range), 32'd1);
    chk("rg_100_mis", 32'(dec_fault_misalign), 32'd0);
    chk("rg_100_instr", dec_instr, 32'h0000_0013);
    chk("rg_halted", 32'(fetch_halted), 32'd1);

    // fetch_en low: PC holds and nothing is pushed.
    redirect_valid = 1'b1; redirect_pc = 32'h10; fetch_en = 1'b0;
    step();
    redirect_valid = 1'b0;
    step(); step();
    chk("fen_valid", 32'(dec_valid), 32'd0);
    chk("fen_imem_pc", imem_pc, 32'h10);
    fetch_en = 1'b1;
    step();
    chk("fen_resume", dec_pc, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
